// File: rtl/reloj_display_driver.sv
`default_nettype none
// ============================================================================
//  Module      : reloj_display_driver
//  Description : Display side of the digital clock. Takes binary hours and
//                minutes, splits them into BCD digits and scans them onto a
//                4-digit multiplexed 7-segment display (HH:MM) with colon,
//                blinking the pair currently being edited.
//  Revision    : 1.0  - initial release
// ============================================================================
module reloj_display_driver #(
    parameter int SCAN_DIV       = 50000,     // cycles each digit stays lit
    parameter int BLINK_DIV      = 25000000,  // cycles per blink half-period
    parameter bit SEG_ACTIVE_LOW = 1'b1,      // segment line polarity
    parameter bit AN_ACTIVE_LOW  = 1'b1       // anode line polarity
) (
    input  logic       clock_i,
    input  logic       reset_i,
    input  logic [4:0] horas_i,
    input  logic [5:0] minutos_i,
    input  logic       modifHor_i,
    input  logic       modifMin_i,
    output logic [6:0] segmentos_o,
    output logic [3:0] anodos_o,
    output logic       punto_o
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam int c_scan_w  = (SCAN_DIV  > 1) ? $clog2(SCAN_DIV)  : 1;
    localparam int c_blink_w = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    localparam logic [c_scan_w-1:0]  c_scan_last  = c_scan_w'(SCAN_DIV - 1);
    localparam logic [c_blink_w-1:0] c_blink_last = c_blink_w'(BLINK_DIV - 1);

    // Digit index encoding; the index is also the anode bit position.
    localparam logic [1:0] c_dig_min_u  = 2'd0;
    localparam logic [1:0] c_dig_min_t  = 2'd1;
    localparam logic [1:0] c_dig_hour_u = 2'd2;
    localparam logic [1:0] c_dig_hour_t = 2'd3;

    // Highest legal values of the time fields.
    localparam logic [4:0] c_max_hour = 5'd23;
    localparam logic [5:0] c_max_min  = 6'd59;

    // Active-high segment patterns {g,f,e,d,c,b,a}.
    localparam logic [6:0] c_seg_dash  = 7'h40;
    localparam logic [6:0] c_seg_blank = 7'h00;

    // ------------------------------------------------------------------------
    // Helpers
    // ------------------------------------------------------------------------
    // Binary (0..63) to two BCD digits by repeated compare/subtract; five
    // steps cover every legal value (max 59) without a divider.
    function automatic logic [7:0] to_bcd(input logic [5:0] value);
        logic [5:0] rest;
        logic [3:0] tens;
        rest = value;
        tens = 4'd0;
        for (int step = 0; step < 5; step++) begin
            if (rest >= 6'd10) begin
                rest = rest - 6'd10;
                tens = tens + 4'd1;
            end
        end
        return {tens, 4'(rest)};
    endfunction

    // BCD digit to active-high segment pattern; non-decimal values show a dash.
    function automatic logic [6:0] seg_code(input logic [3:0] digit);
        logic [6:0] code;
        case (digit)
            4'd0:    code = 7'h3F;
            4'd1:    code = 7'h06;
            4'd2:    code = 7'h5B;
            4'd3:    code = 7'h4F;
            4'd4:    code = 7'h66;
            4'd5:    code = 7'h6D;
            4'd6:    code = 7'h7D;
            4'd7:    code = 7'h07;
            4'd8:    code = 7'h7F;
            4'd9:    code = 7'h6F;
            default: code = c_seg_dash;
        endcase
        return code;
    endfunction

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [c_scan_w-1:0]  prescaler_q,   prescaler_d;
    logic [1:0]           index_q,       index_d;
    logic [4:0]           hour_shadow_q, hour_shadow_d;
    logic [5:0]           min_shadow_q,  min_shadow_d;
    logic                 frame_valid_q, frame_valid_d;
    logic [c_blink_w-1:0] blink_cnt_q,   blink_cnt_d;
    logic                 blink_phase_q, blink_phase_d;
    logic [6:0]           seg_q,         seg_d;
    logic [3:0]           an_q,          an_d;
    logic                 punto_q,       punto_d;

    // Combinational intermediates
    logic       w_scan_tc;
    logic       w_frame_tc;
    logic       w_blink_tc;
    logic [7:0] w_hour_bcd;
    logic [7:0] w_min_bcd;
    logic       w_hour_bad;
    logic       w_min_bad;
    logic [3:0] w_digit_val;
    logic       w_digit_dash;
    logic       w_blank;
    logic [6:0] w_seg_active;
    logic [3:0] w_an_active;
    logic       w_punto_active;

    // ------------------------------------------------------------------------
    // Next-state: scan prescaler, digit index, frame shadows and blink timer
    // ------------------------------------------------------------------------
    always_comb begin
        w_scan_tc  = (prescaler_q == c_scan_last);
        // Shadows load only as the index wraps 3->0 so a frame never mixes
        // an old and a new time value.
        w_frame_tc = w_scan_tc && (index_q == c_dig_hour_t);
        w_blink_tc = (blink_cnt_q == c_blink_last);

        prescaler_d   = w_scan_tc ? '0 : prescaler_q + c_scan_w'(1);
        index_d       = w_scan_tc ? index_q + 2'd1 : index_q;
        hour_shadow_d = w_frame_tc ? horas_i   : hour_shadow_q;
        min_shadow_d  = w_frame_tc ? minutos_i : min_shadow_q;
        // Nothing is lit until the first frame has real data in the shadows.
        frame_valid_d = frame_valid_q | w_frame_tc;

        // Blink timer free-runs; edit inputs only gate the anodes.
        blink_cnt_d   = w_blink_tc ? '0 : blink_cnt_q + c_blink_w'(1);
        blink_phase_d = blink_phase_q ^ w_blink_tc;
    end

    // ------------------------------------------------------------------------
    // Output decode: select digit of the current index, blank and colon
    // ------------------------------------------------------------------------
    always_comb begin
        w_hour_bcd = to_bcd({1'b0, hour_shadow_q});
        w_min_bcd  = to_bcd(min_shadow_q);
        w_hour_bad = (hour_shadow_q > c_max_hour);
        w_min_bad  = (min_shadow_q  > c_max_min);

        w_digit_val  = 4'd0;
        w_digit_dash = 1'b0;
        case (index_q)
            c_dig_min_u: begin
                w_digit_val  = w_min_bcd[3:0];
                w_digit_dash = w_min_bad;
            end
            c_dig_min_t: begin
                w_digit_val  = w_min_bcd[7:4];
                w_digit_dash = w_min_bad;
            end
            c_dig_hour_u: begin
                w_digit_val  = w_hour_bcd[3:0];
                w_digit_dash = w_hour_bad;
            end
            default: begin
                w_digit_val  = w_hour_bcd[7:4];
                w_digit_dash = w_hour_bad;
            end
        endcase

        // Index bit 1 separates the hour pair (3,2) from the minute pair (1,0).
        w_blank = blink_phase_q & (index_q[1] ? modifHor_i : modifMin_i);

        if (!frame_valid_q) begin
            w_seg_active = c_seg_blank;
            w_an_active  = 4'b0000;
        end else begin
            w_seg_active = w_digit_dash ? c_seg_dash : seg_code(w_digit_val);
            w_an_active  = w_blank ? 4'b0000 : (4'b0001 << index_q);
        end

        // Colon sits after the hour units digit and blinks at the blink rate.
        w_punto_active = frame_valid_q & (index_q == c_dig_hour_u) & ~blink_phase_q;

        seg_d   = SEG_ACTIVE_LOW ? ~w_seg_active   : w_seg_active;
        an_d    = AN_ACTIVE_LOW  ? ~w_an_active    : w_an_active;
        punto_d = SEG_ACTIVE_LOW ? ~w_punto_active : w_punto_active;
    end

    // ------------------------------------------------------------------------
    // State register: counters, shadows and the registered display outputs
    // ------------------------------------------------------------------------
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            prescaler_q   <= '0;
            index_q       <= c_dig_hour_t;
            hour_shadow_q <= '0;
            min_shadow_q  <= '0;
            frame_valid_q <= 1'b0;
            blink_cnt_q   <= '0;
            blink_phase_q <= 1'b0;
            seg_q         <= SEG_ACTIVE_LOW ? ~c_seg_blank : c_seg_blank;
            an_q          <= AN_ACTIVE_LOW  ? 4'b1111 : 4'b0000;
            punto_q       <= SEG_ACTIVE_LOW ? 1'b1 : 1'b0;
        end else begin
            prescaler_q   <= prescaler_d;
            index_q       <= index_d;
            hour_shadow_q <= hour_shadow_d;
            min_shadow_q  <= min_shadow_d;
            frame_valid_q <= frame_valid_d;
            blink_cnt_q   <= blink_cnt_d;
            blink_phase_q <= blink_phase_d;
            seg_q         <= seg_d;
            an_q          <= an_d;
            punto_q       <= punto_d;
        end
    end

    assign segmentos_o = seg_q;
    assign anodos_o    = an_q;
    assign punto_o     = punto_q;

endmodule
`default_nettype wire
